// File: rtl/bsg_axi_pkg.sv
// Shared AXI4 encodings: response codes and burst types.
package bsg_axi_pkg;

  localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axi_resp_slverr_gp = 2'b10;

  localparam logic [1:0] axi_burst_fixed_gp = 2'b00;
  localparam logic [1:0] axi_burst_incr_gp  = 2'b01;
  localparam logic [1:0] axi_burst_wrap_gp  = 2'b10;

  localparam int axi_len_width_gp = 8;

endpackage

// File: rtl/bsg_axi_burst_addr_gen.sv
// Beat address / last-beat generator for one AXI burst.
// FIXED repeats the aligned base; INCR and WRAP both step by one data word.
module bsg_axi_burst_addr_gen
  import bsg_axi_pkg::*;
#(parameter int addr_width_p    = 32
 ,parameter int lg_strb_width_p = 2
 )
 (input  logic [addr_width_p-1:0]     base_addr_i
 ,input  logic [axi_len_width_gp-1:0] len_i
 ,input  logic [1:0]                  burst_i
 ,input  logic [axi_len_width_gp-1:0] beat_i
 ,output logic [addr_width_p-1:0]     addr_o
 ,output logic                        last_o
 );

  logic [addr_width_p-1:0] aligned, offset;

  always_comb begin
    aligned = (base_addr_i >> lg_strb_width_p) << lg_strb_width_p;
    offset  = addr_width_p'(beat_i) << lg_strb_width_p;
    if (burst_i == axi_burst_fixed_gp)
      offset = '0;
    // carry out of the top bit is dropped on purpose
    addr_o = aligned + offset;
  end

  assign last_o = (beat_i == len_i);

endmodule

// File: rtl/bsg_axi_to_mem_responder.sv
// AXI4 responder converting each AW/W or AR burst beat into one request on a
// single-port valid/ready memory interface. One burst in flight at a time.
// Optional: BSG_AXI_RESP_WLAST_CHECK_EN flags wlast/beat-count mismatch as SLVERR.
module bsg_axi_to_mem_responder
  import bsg_axi_pkg::*;
#(parameter int addr_width_p     = 32
 ,parameter int axi_id_width_p   = 4
 ,parameter int axi_data_width_p = 32
 ,localparam int strb_width_lp    = axi_data_width_p >> 3
 ,localparam int lg_strb_width_lp = $clog2(strb_width_lp)
 )
 (input  logic                          clk_i
 ,input  logic                          reset_i

 ,input  logic [axi_id_width_p-1:0]     axi_awid_i
 ,input  logic [addr_width_p-1:0]       axi_awaddr_i
 ,input  logic [7:0]                    axi_awlen_i
 ,input  logic [2:0]                    axi_awsize_i
 ,input  logic [1:0]                    axi_awburst_i
 ,input  logic                          axi_awvalid_i
 ,output logic                          axi_awready_o

 ,input  logic [axi_data_width_p-1:0]   axi_wdata_i
 ,input  logic [strb_width_lp-1:0]      axi_wstrb_i
 ,input  logic                          axi_wlast_i
 ,input  logic                          axi_wvalid_i
 ,output logic                          axi_wready_o

 ,output logic [axi_id_width_p-1:0]     axi_bid_o
 ,output logic [1:0]                    axi_bresp_o
 ,output logic                          axi_bvalid_o
 ,input  logic                          axi_bready_i

 ,input  logic [axi_id_width_p-1:0]     axi_arid_i
 ,input  logic [addr_width_p-1:0]       axi_araddr_i
 ,input  logic [7:0]                    axi_arlen_i
 ,input  logic [2:0]                    axi_arsize_i
 ,input  logic [1:0]                    axi_arburst_i
 ,input  logic                          axi_arvalid_i
 ,output logic                          axi_arready_o

 ,output logic [axi_id_width_p-1:0]     axi_rid_o
 ,output logic [axi_data_width_p-1:0]   axi_rdata_o
 ,output logic [1:0]                    axi_rresp_o
 ,output logic                          axi_rlast_o
 ,output logic                          axi_rvalid_o
 ,input  logic                          axi_rready_i

 ,output logic                          mem_v_o
 ,output logic                          mem_w_o
 ,output logic [addr_width_p-1:0]       mem_addr_o
 ,output logic [axi_data_width_p-1:0]   mem_data_o
 ,output logic [strb_width_lp-1:0]      mem_mask_o
 ,input  logic                          mem_ready_and_i

 ,input  logic [axi_data_width_p-1:0]   mem_data_i
 ,input  logic                          mem_data_v_i
 ,output logic                          mem_data_ready_and_o
 );

  typedef enum logic [2:0] {e_idle, e_write, e_wresp, e_rreq, e_rwait, e_rresp} state_e;

  typedef struct packed {
    logic [axi_id_width_p-1:0] id;
    logic [addr_width_p-1:0]   addr;
    logic [7:0]                len;
    logic [1:0]                burst;
    logic                      err;
  } burst_s;

  state_e                        state_r, state_n;
  burst_s                        burst_r;
  logic [7:0]                    beat_r;
  logic                          last_grant_r;  // 1: read won last
  logic [axi_data_width_p-1:0]   rdata_r;
  logic [addr_width_p-1:0]       beat_addr;
  logic                          beat_last;

  logic grant_w, grant_r;
  logic aw_hs, ar_hs, w_hs, rreq_hs, rdata_hs, r_hs, b_hs;

  bsg_axi_burst_addr_gen
   #(.addr_width_p   (addr_width_p)
    ,.lg_strb_width_p(lg_strb_width_lp)
    )
   addr_gen
    (.base_addr_i(burst_r.addr)
    ,.len_i      (burst_r.len)
    ,.burst_i    (burst_r.burst)
    ,.beat_i     (beat_r)
    ,.addr_o     (beat_addr)
    ,.last_o     (beat_last)
    );

  // Contested IDLE cycles alternate; an uncontested channel always wins.
  assign grant_w = axi_awvalid_i & (~axi_arvalid_i |  last_grant_r);
  assign grant_r = axi_arvalid_i & (~axi_awvalid_i | ~last_grant_r);

  assign aw_hs    = axi_awready_o;
  assign ar_hs    = axi_arready_o;
  assign w_hs     = axi_wvalid_i & axi_wready_o;
  assign rreq_hs  = mem_v_o & ~mem_w_o & mem_ready_and_i;
  assign rdata_hs = mem_data_v_i & mem_data_ready_and_o;
  assign r_hs     = axi_rvalid_o & axi_rready_i;
  assign b_hs     = axi_bvalid_o & axi_bready_i;

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (aw_hs) state_n = e_write;
               else if (ar_hs) state_n = e_rreq;
      e_write: if (w_hs & beat_last) state_n = e_wresp;
      e_wresp: if (b_hs) state_n = e_idle;
      e_rreq:  if (rreq_hs) state_n = e_rwait;
      e_rwait: if (rdata_hs) state_n = e_rresp;
      e_rresp: if (r_hs) state_n = beat_last ? e_idle : e_rreq;
      default: state_n = e_idle;
    endcase
  end

  // Readies in IDLE are gated by reset so nothing handshakes while held in reset.
  always_comb begin
    axi_awready_o        = 1'b0;
    axi_arready_o        = 1'b0;
    axi_wready_o         = 1'b0;
    axi_bvalid_o         = 1'b0;
    axi_rvalid_o         = 1'b0;
    mem_v_o              = 1'b0;
    mem_w_o              = 1'b0;
    mem_data_ready_and_o = 1'b0;
    unique case (state_r)
      e_idle: begin
        axi_awready_o = grant_w & ~reset_i;
        axi_arready_o = grant_r & ~reset_i;
      end
      e_write: begin
        mem_v_o      = axi_wvalid_i;
        mem_w_o      = 1'b1;
        axi_wready_o = mem_ready_and_i;
      end
      e_wresp: axi_bvalid_o         = 1'b1;
      e_rreq:  mem_v_o              = 1'b1;
      e_rwait: mem_data_ready_and_o = 1'b1;
      e_rresp: axi_rvalid_o         = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr_o  = beat_addr;
  assign mem_data_o  = axi_wdata_i;
  assign mem_mask_o  = (state_r == e_write) ? axi_wstrb_i : '0;

  assign axi_bid_o   = burst_r.id;
  assign axi_bresp_o = burst_r.err ? axi_resp_slverr_gp : axi_resp_okay_gp;
  assign axi_rid_o   = burst_r.id;
  assign axi_rresp_o = burst_r.err ? axi_resp_slverr_gp : axi_resp_okay_gp;
  assign axi_rdata_o = rdata_r;
  assign axi_rlast_o = (state_r == e_rresp) & beat_last;

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      burst_r      <= '0;
      beat_r       <= '0;
      last_grant_r <= 1'b1;
      rdata_r      <= '0;
    end else begin
      if (aw_hs) begin
        burst_r      <= '{id: axi_awid_i, addr: axi_awaddr_i, len: axi_awlen_i,
                          burst: axi_awburst_i, err: (axi_awsize_i != 3'(lg_strb_width_lp))};
        beat_r       <= '0;
        last_grant_r <= 1'b0;
      end else if (ar_hs) begin
        burst_r      <= '{id: axi_arid_i, addr: axi_araddr_i, len: axi_arlen_i,
                          burst: axi_arburst_i, err: (axi_arsize_i != 3'(lg_strb_width_lp))};
        beat_r       <= '0;
        last_grant_r <= 1'b1;
      end
      // beat count follows awlen; the counter never steps past len
      if (w_hs) begin
        if (~beat_last) beat_r <= beat_r + 8'd1;
`ifdef BSG_AXI_RESP_WLAST_CHECK_EN
        if (axi_wlast_i != beat_last) burst_r.err <= 1'b1;
`endif
      end
      if (rdata_hs) rdata_r <= mem_data_i;
      if (r_hs & ~beat_last) beat_r <= beat_r + 8'd1;
    end

`ifndef BSG_AXI_RESP_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = axi_wlast_i;
`endif

endmodule

// File: tb/tb_bsg_axi_to_mem_responder.sv
// Scoreboard bench for bsg_axi_to_mem_responder (A=32, ID=4, D=32).
module tb_bsg_axi_to_mem_responder;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  axi_awid_i = '0;    logic [31:0] axi_awaddr_i = '0;
  logic [7:0]  axi_awlen_i = '0;   logic [2:0]  axi_awsize_i = '0;
  logic [1:0]  axi_awburst_i = '0; logic        axi_awvalid_i = 1'b0;
  logic        axi_awready_o;
  logic [31:0] axi_wdata_i = '0;   logic [3:0]  axi_wstrb_i = '0;
  logic        axi_wlast_i = 1'b0; logic        axi_wvalid_i = 1'b0;
  logic        axi_wready_o;
  logic [3:0]  axi_bid_o;          logic [1:0]  axi_bresp_o;
  logic        axi_bvalid_o;       logic        axi_bready_i = 1'b1;
  logic [3:0]  axi_arid_i = '0;    logic [31:0] axi_araddr_i = '0;
  logic [7:0]  axi_arlen_i = '0;   logic [2:0]  axi_arsize_i = '0;
  logic [1:0]  axi_arburst_i = '0; logic        axi_arvalid_i = 1'b0;
  logic        axi_arready_o;
  logic [3:0]  axi_rid_o;          logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;        logic        axi_rlast_o;
  logic        axi_rvalid_o;       logic        axi_rready_i = 1'b1;
  logic        mem_v_o, mem_w_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_mask_o;
  logic        mem_ready_and_i = 1'b1;
  logic [31:0] mem_data_i = '0;
  logic        mem_data_v_i = 1'b0;
  logic        mem_data_ready_and_o;

  always #5 clk = ~clk;

  bsg_axi_to_mem_responder dut
    (.clk_i(clk), .reset_i(reset_i)
    ,.axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i)
    ,.axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i)
    ,.axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o)
    ,.axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i)
    ,.axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o)
    ,.axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o)
    ,.axi_bready_i(axi_bready_i)
    ,.axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i)
    ,.axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i)
    ,.axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o)
    ,.axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o)
    ,.axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    ,.mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o)
    ,.mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_ready_and_i(mem_ready_and_i)
    ,.mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i)
    ,.mem_data_ready_and_o(mem_data_ready_and_o)
    );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  r_t  exp_r[$];
  logic [31:0] rd_q[$];
  int n_cmp = 0, n_err = 0;
  wr_t we; b_t be; r_t re;
  logic acc = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Scoreboard monitor (mid-cycle) and memory model (just after the edge).
  always begin
    @(negedge clk);
    if (!reset_i) begin
      if (mem_v_o && mem_ready_and_i && mem_w_o) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_err++; $display("FAIL mem_write unexpected got addr=%h data=%h", mem_addr_o, mem_data_o);
        end else begin
          we = exp_wr.pop_front();
          if (mem_addr_o !== we.addr || mem_data_o !== we.data || mem_mask_o !== we.mask) begin
            n_err++;
            $display("FAIL mem_write got %h/%h/%h want %h/%h/%h",
                     mem_addr_o, mem_data_o, mem_mask_o, we.addr, we.data, we.mask);
          end
        end
      end
      if (mem_v_o && mem_ready_and_i && !mem_w_o) rd_q.push_back(mem_addr_o);
      acc = mem_data_v_i && mem_data_ready_and_o;
      if (axi_bvalid_o && axi_bready_i) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++; $display("FAIL b_resp unexpected got id=%h resp=%b", axi_bid_o, axi_bresp_o);
        end else begin
          be = exp_b.pop_front();
          if (axi_bid_o !== be.id || axi_bresp_o !== be.resp) begin
            n_err++;
            $display("FAIL b_resp got id=%h resp=%b want id=%h resp=%b", axi_bid_o, axi_bresp_o, be.id, be.resp);
          end
        end
      end
      if (axi_rvalid_o && axi_rready_i) begin
        n_cmp++;
        if (exp_r.size() == 0) begin
          n_err++; $display("FAIL r_beat unexpected got data=%h", axi_rdata_o);
        end else begin
          re = exp_r.pop_front();
          if (axi_rid_o !== re.id || axi_rdata_o !== re.data || axi_rresp_o !== re.resp || axi_rlast_o !== re.last) begin
            n_err++;
            $display("FAIL r_beat got id=%h d=%h resp=%b last=%b want id=%h d=%h resp=%b last=%b",
                     axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, re.id, re.data, re.resp, re.last);
          end
        end
      end
    end
    @(posedge clk); #1;
    mem_ready_and_i = ($urandom_range(0, 3) != 0);
    if (reset_i) begin
      rd_q.delete(); mem_data_v_i = 1'b0; acc = 1'b0;
    end else begin
      if (acc) begin mem_data_v_i = 1'b0; acc = 1'b0; void'(rd_q.pop_front()); end
      if (!mem_data_v_i && rd_q.size() != 0) begin mem_data_v_i = 1'b1; mem_data_i = mem_val(rd_q[0]); end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len; axi_awsize_i = size;
    axi_awburst_i = burst; axi_awvalid_i = 1'b1;
    do begin @(negedge clk); t++; end while (!axi_awready_o && t < 200);
    if (!axi_awready_o) begin n_cmp++; n_err++; $display("FAIL aw_timeout got ready=0 want 1"); end
    @(posedge clk); #1; axi_awvalid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len; axi_arsize_i = size;
    axi_arburst_i = burst; axi_arvalid_i = 1'b1;
    do begin @(negedge clk); t++; end while (!axi_arready_o && t < 200);
    if (!axi_arready_o) begin n_cmp++; n_err++; $display("FAIL ar_timeout got ready=0 want 1"); end
    @(posedge clk); #1; axi_arvalid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    axi_wdata_i = data; axi_wstrb_i = strb; axi_wlast_i = last; axi_wvalid_i = 1'b1;
    do begin @(negedge clk); t++; end while (!axi_wready_o && t < 200);
    if (!axi_wready_o) begin n_cmp++; n_err++; $display("FAIL w_timeout got ready=0 want 1"); end
    @(posedge clk); #1; axi_wvalid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_wr.size() + exp_b.size() + exp_r.size()) != 0 && t < 500) begin @(negedge clk); t++; end
    if ((exp_wr.size() + exp_b.size() + exp_r.size()) != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout got pending wr=%0d b=%0d r=%0d want 0", exp_wr.size(), exp_b.size(), exp_r.size());
      exp_wr.delete(); exp_b.delete(); exp_r.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_wr.delete(); exp_b.delete(); exp_r.delete();
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, mem_v_o, mem_data_ready_and_o} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs got aw=%b ar=%b w=%b b=%b r=%b mv=%b mdr=%b want all 0",
        axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, mem_v_o, mem_data_ready_and_o);
    end
    n_cmp++;
    if ({axi_bid_o, axi_rdata_o, axi_rlast_o} !== 37'b0) begin
      n_err++; $display("FAIL reset_regs got bid=%h rdata=%h rlast=%b want 0", axi_bid_o, axi_rdata_o, axi_rlast_o);
    end
    axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    @(posedge clk); #1 reset_i = 1'b0;
  endtask

  task automatic test_write_burst();
    send_aw(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i), (i == 1) ? 4'h3 : 4'hF});
      send_w(32'hD000_0000 + 32'(i), (i == 1) ? 4'h3 : 4'hF, i == 3);
    end
    exp_b.push_back('{4'h5, 2'b00});
    wait_drain();
  endtask

  task automatic test_read_burst();
    logic [31:0] d0;
    logic        l0;
    int          t = 0;
    axi_rready_i = 1'b0;
    exp_r.push_back('{4'h3, mem_val(32'h200), 2'b00, 1'b0});
    exp_r.push_back('{4'h3, mem_val(32'h204), 2'b00, 1'b1});
    send_ar(4'h3, 32'h200, 8'd1, 3'd2, 2'b01);
    while (!axi_rvalid_o && t < 100) begin @(negedge clk); t++; end
    d0 = axi_rdata_o; l0 = axi_rlast_o;
    n_cmp++;
    if (d0 !== mem_val(32'h200) || l0 !== 1'b0) begin
      n_err++; $display("FAIL read_first_beat got d=%h last=%b want d=%h last=0", d0, l0, mem_val(32'h200));
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== d0 || axi_rlast_o !== l0) begin
        n_err++; $display("FAIL read_hold got v=%b d=%h last=%b want v=1 d=%h last=%b",
                          axi_rvalid_o, axi_rdata_o, axi_rlast_o, d0, l0);
      end
    end
    @(posedge clk); #1 axi_rready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_fixed_burst();
    send_aw(4'h7, 32'h403, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{32'h400, 32'hF1F0_0000 + 32'(i), 4'hF});
      send_w(32'hF1F0_0000 + 32'(i), 4'hF, i == 2);
    end
    exp_b.push_back('{4'h7, 2'b00});
    wait_drain();
  endtask

  task automatic test_wrap_read();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'hFFFF_FFF8 + 32'(4 * i);
      exp_r.push_back('{4'hA, mem_val(a), 2'b00, i == 2});
    end
    send_ar(4'hA, 32'hFFFF_FFF8, 8'd2, 3'd2, 2'b10);
    wait_drain();
  endtask

  task automatic test_size_err();
    exp_r.push_back('{4'h9, mem_val(32'h300), 2'b10, 1'b1});
    send_ar(4'h9, 32'h300, 8'd0, 3'd0, 2'b01);
    wait_drain();
    send_aw(4'hB, 32'h340, 8'd1, 3'd1, 2'b01);
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back('{32'h340 + 32'(4 * i), 32'h5150_0000 + 32'(i), 4'hF});
      send_w(32'h5150_0000 + 32'(i), 4'hF, i == 1);
    end
    exp_b.push_back('{4'hB, 2'b10});
    wait_drain();
  endtask

  task automatic test_wlast();
    send_aw(4'h2, 32'h700, 8'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{32'h700 + 32'(4 * i), 32'h7770_0000 + 32'(i), 4'hF});
      send_w(32'h7770_0000 + 32'(i), 4'hF, i == 1);
    end
`ifdef BSG_AXI_RESP_WLAST_CHECK_EN
    exp_b.push_back('{4'h2, 2'b10});
`else
    exp_b.push_back('{4'h2, 2'b00});
`endif
    wait_drain();
  endtask

  task automatic test_arbitration();
    do_reset();
    axi_awid_i = 4'h1; axi_awaddr_i = 32'h500; axi_awlen_i = 8'd0; axi_awsize_i = 3'd2; axi_awburst_i = 2'b01;
    axi_arid_i = 4'h6; axi_araddr_i = 32'h600; axi_arlen_i = 8'd0; axi_arsize_i = 3'd2; axi_arburst_i = 2'b01;
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (axi_awready_o !== 1'b1 || axi_arready_o !== 1'b0) begin
      n_err++; $display("FAIL arb_first got aw=%b ar=%b want aw=1 ar=0", axi_awready_o, axi_arready_o);
    end
    @(posedge clk); #1 axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    exp_wr.push_back('{32'h500, 32'hAB00_0001, 4'hF});
    exp_b.push_back('{4'h1, 2'b00});
    send_w(32'hAB00_0001, 4'hF, 1'b1);
    wait_drain();
    axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (axi_awready_o !== 1'b0 || axi_arready_o !== 1'b1) begin
      n_err++; $display("FAIL arb_second got aw=%b ar=%b want aw=0 ar=1", axi_awready_o, axi_arready_o);
    end
    exp_r.push_back('{4'h6, mem_val(32'h600), 2'b00, 1'b1});
    @(posedge clk); #1 axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_burst();
    send_aw(4'h4, 32'h800, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back('{32'h800 + 32'(4 * i), 32'h8880_0000 + 32'(i), 4'hF});
      send_w(32'h8880_0000 + 32'(i), 4'hF, 1'b0);
    end
    axi_wdata_i = 32'h8880_0002; axi_wstrb_i = 4'hF; axi_wvalid_i = 1'b1;
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if ({axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, mem_v_o, mem_data_ready_and_o} !== 7'b0) begin
      n_err++; $display("FAIL reset_mid_outputs got w=%b mv=%b b=%b want all 0", axi_wready_o, mem_v_o, axi_bvalid_o);
    end
    n_cmp++;
    if (exp_wr.size() !== 0) begin
      n_err++; $display("FAIL reset_mid_beats got pending=%0d want 0", exp_wr.size());
    end
    axi_wvalid_i = 1'b0;
    exp_wr.delete(); exp_b.delete(); exp_r.delete();
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_aw(4'hC, 32'h900, 8'd0, 3'd2, 2'b01);
    exp_wr.push_back('{32'h900, 32'h9990_0000, 4'hF});
    exp_b.push_back('{4'hC, 2'b00});
    send_w(32'h9990_0000, 4'hF, 1'b1);
    wait_drain();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_fixed_burst();
    test_wrap_read();
    test_size_err();
    test_wlast();
    test_arbitration();
    test_reset_mid_burst();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
